// File: rtl/ysyx_24110006_lsu_pkg.sv
// Shared LSU definitions: opcodes, funct3 size codes, FSM state encoding and access-legality helper.
// Pure constants and functions: no latency, no flow control.
package ysyx_24110006_lsu_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    // Unsigned sizes exist only for loads; an illegal size is reported like a misalignment.
    function automatic logic access_ok(input logic is_store, input logic [2:0] func,
                                       input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (func)
            F3_B:  ok = 1'b1;
            F3_H:  ok = ~off[0];
            F3_W:  ok = (off == 2'b00);
            F3_BU: ok = ~is_store;
            F3_HU: ok = ~is_store & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ysyx_24110006_lsu_align.sv
// Byte-lane steering: store strobes/data shifted into lanes, load word shifted down and extended.
// Purely combinational, zero latency; no backpressure.
module ysyx_24110006_lsu_align
    import ysyx_24110006_lsu_pkg::*;
(
    input  logic        is_store_i,
    input  logic [2:0]  st_func_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] rs2_i,
    input  logic [2:0]  ld_func_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] rdata_i,
    output logic        ok_o,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o
);

    logic [3:0]  base_mask;
    logic [31:0] ld_shifted;

    always_comb begin
        base_mask = 4'b0000;
        case (st_func_i)
            F3_B:    base_mask = 4'b0001;
            F3_H:    base_mask = 4'b0011;
            F3_W:    base_mask = 4'b1111;
            default: base_mask = 4'b0000;
        endcase
        wmask_o = base_mask << st_off_i;
        wdata_o = rs2_i << {st_off_i, 3'b000};
        ok_o    = access_ok(is_store_i, st_func_i, st_off_i);
    end

    always_comb begin
        ld_shifted = rdata_i >> {ld_off_i, 3'b000};
        case (ld_func_i)
            F3_B:    ld_data_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            F3_BU:   ld_data_o = {24'h000000, ld_shifted[7:0]};
            F3_H:    ld_data_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            F3_HU:   ld_data_o = {16'h0000, ld_shifted[15:0]};
            default: ld_data_o = ld_shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_24110006_lsu.sv
// Load/store stage: IDLE accepts, MEM runs one req/ack bus cycle, RESP holds the result for writeback.
// Pass-through latency 1, memory latency ack-wait + 1; o_ready only in IDLE, RESP holds until i_ready.
module ysyx_24110006_lsu
    import ysyx_24110006_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [6:0]  i_op,
    input  logic [2:0]  i_func,
    input  logic [31:0] i_result,
    input  logic [31:0] i_reg_src2,
    input  logic        i_reg_wen,
    output logic        o_mem_req,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wmask,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_wb_data,
    output logic        o_wb_wen,
    output logic        o_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    lsu_state_e       state_q, state_d;
    logic [31:2]      addr_q, addr_d;
    logic [1:0]       off_q, off_d;
    logic [2:0]       func_q, func_d;
    logic             mem_wen_q, mem_wen_d;
    logic [3:0]       wmask_q, wmask_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             wb_wen_q, wb_wen_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        is_load, is_store, al_ok;
    logic [3:0]  al_wmask;
    logic [31:0] al_wdata, al_ld_data;
    logic        expired;

    assign is_load  = (i_op == OP_LOAD);
    assign is_store = (i_op == OP_STORE);
    assign expired  = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    ysyx_24110006_lsu_align u_align (
        .is_store_i (is_store),
        .st_func_i  (i_func),
        .st_off_i   (i_result[1:0]),
        .rs2_i      (i_reg_src2),
        .ld_func_i  (func_q),
        .ld_off_i   (off_q),
        .rdata_i    (i_mem_rdata),
        .ok_o       (al_ok),
        .wmask_o    (al_wmask),
        .wdata_o    (al_wdata),
        .ld_data_o  (al_ld_data)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        off_d     = off_q;
        func_d    = func_q;
        mem_wen_d = mem_wen_q;
        wmask_d   = wmask_q;
        wdata_d   = wdata_q;
        wb_data_d = wb_data_q;
        wb_wen_d  = wb_wen_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    addr_d    = i_result[31:2];
                    off_d     = i_result[1:0];
                    func_d    = i_func;
                    cnt_d     = '0;
                    mem_wen_d = 1'b0;
                    wmask_d   = 4'b0000;
                    wdata_d   = 32'h0;
                    wb_data_d = 32'h0;
                    wb_wen_d  = 1'b0;
                    err_d     = 1'b0;
                    state_d   = ST_RESP;
                    if ((is_load || is_store) && al_ok) begin
                        state_d   = ST_MEM;
                        mem_wen_d = is_store;
                        wmask_d   = is_store ? al_wmask : 4'b0000;
                        wdata_d   = is_store ? al_wdata : 32'h0;
                        wb_wen_d  = i_reg_wen;
                    end else if (is_load || is_store) begin
                        err_d = 1'b1;
                    end else begin
                        wb_data_d = i_result;
                        wb_wen_d  = i_reg_wen;
                    end
                end
            end
            ST_MEM: begin
                // An ack arriving on the expiry cycle still completes normally.
                if (i_mem_ack) begin
                    state_d   = ST_RESP;
                    mem_wen_d = 1'b0;
                    wmask_d   = 4'b0000;
                    if (!mem_wen_q) wb_data_d = al_ld_data;
                end else if (expired) begin
                    state_d   = ST_RESP;
                    mem_wen_d = 1'b0;
                    wmask_d   = 4'b0000;
                    err_d     = 1'b1;
                    wb_wen_d  = 1'b0;
                    wb_data_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (i_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            off_q     <= 2'b00;
            func_q    <= 3'b000;
            mem_wen_q <= 1'b0;
            wmask_q   <= 4'b0000;
            wdata_q   <= 32'h0;
            wb_data_q <= 32'h0;
            wb_wen_q  <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            off_q     <= off_d;
            func_q    <= func_d;
            mem_wen_q <= mem_wen_d;
            wmask_q   <= wmask_d;
            wdata_q   <= wdata_d;
            wb_data_q <= wb_data_d;
            wb_wen_q  <= wb_wen_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_ready     = (state_q == ST_IDLE);
    assign o_mem_req   = (state_q == ST_MEM);
    assign o_valid     = (state_q == ST_RESP);
    assign o_mem_wen   = mem_wen_q;
    assign o_mem_addr  = {addr_q, 2'b00};
    assign o_mem_wdata = wdata_q;
    assign o_mem_wmask = wmask_q;
    assign o_wb_data   = wb_data_q;
    assign o_wb_wen    = wb_wen_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_ysyx_24110006_lsu.sv
// Scoreboard bench for the LSU: a bus responder checks requests and acks them,
// a writeback monitor pops expected results on every o_valid/i_ready handshake.
module tb_ysyx_24110006_lsu;

    localparam int TO = 4;
    localparam logic [6:0] OPL = 7'b0000011;
    localparam logic [6:0] OPS = 7'b0100011;
    localparam logic [6:0] OPA = 7'b0110011;

    typedef struct {
        logic [31:0] data;
        logic        wen;
        logic        err;
        logic        chk_data;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        int          mode;  // 0 ack after delay, 1 never ack (timeout), 2 aborted by reset
    } bus_exp_t;

    logic        i_clk, i_rst_n, i_valid, o_ready;
    logic [6:0]  i_op;
    logic [2:0]  i_func;
    logic [31:0] i_result, i_reg_src2;
    logic        i_reg_wen;
    logic        o_mem_req, o_mem_wen;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_wmask;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_valid, i_ready;
    logic [31:0] o_wb_data;
    logic        o_wb_wen, o_err;

    logic resp_ack, stray_ack;
    assign i_mem_ack = resp_ack | stray_ack;

    wb_exp_t  wb_q[$];
    bus_exp_t bus_q[$];
    int total = 0;
    int bad   = 0;

    ysyx_24110006_lsu #(.TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_func(i_func), .i_result(i_result), .i_reg_src2(i_reg_src2),
        .i_reg_wen(i_reg_wen), .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_valid(o_valid),
        .i_ready(i_ready), .o_wb_data(o_wb_data), .o_wb_wen(o_wb_wen), .o_err(o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Bus responder / request checker.
    initial begin
        bus_exp_t b;
        int n;
        resp_ack = 1'b0;
        i_mem_rdata = 32'h0;
        forever begin
            @(negedge i_clk);
            if (i_rst_n && o_mem_req) begin
                if (bus_q.size() == 0) begin
                    check("unexpected_req", {31'h0, o_mem_req}, 32'h0);
                    n = 0;
                    while (o_mem_req && n < 100) begin @(negedge i_clk); n++; end
                end else begin
                    b = bus_q.pop_front();
                    check("bus_addr", o_mem_addr, b.addr);
                    check("bus_wen", {31'h0, o_mem_wen}, {31'h0, b.wen});
                    check("bus_wmask", {28'h0, o_mem_wmask}, {28'h0, b.wmask});
                    if (b.wen) check("bus_wdata", o_mem_wdata, b.wdata);
                    if (b.mode == 0) begin
                        repeat (b.delay) @(negedge i_clk);
                        if (b.delay > 0) begin
                            check("req_held", {31'h0, o_mem_req}, 32'h1);
                            check("addr_stable", o_mem_addr, b.addr);
                        end
                        resp_ack = 1'b1;
                        i_mem_rdata = b.rdata;
                        @(posedge i_clk);
                        #1;
                        resp_ack = 1'b0;
                        i_mem_rdata = 32'h0;
                    end else begin
                        n = 0;
                        while (o_mem_req && n < 100) begin @(negedge i_clk); n++; end
                        if (b.mode == 1) check("timeout_req_cycles", n, TO);
                    end
                end
            end
        end
    end

    // Writeback monitor.
    initial begin
        wb_exp_t e;
        forever begin
            @(negedge i_clk);
            if (i_rst_n && o_valid && i_ready) begin
                if (wb_q.size() == 0) begin
                    check("unexpected_wb", {31'h0, o_valid}, 32'h0);
                end else begin
                    e = wb_q.pop_front();
                    check("wb_err", {31'h0, o_err}, {31'h0, e.err});
                    check("wb_wen", {31'h0, o_wb_wen}, {31'h0, e.wen});
                    if (e.chk_data) check("wb_data", o_wb_data, e.data);
                end
            end
        end
    end

    task automatic issue(input logic [6:0] op, input logic [2:0] f, input logic [31:0] res,
                         input logic [31:0] rs2, input logic wen);
        int n;
        n = 0;
        @(posedge i_clk);
        #1;
        i_valid = 1'b1; i_op = op; i_func = f; i_result = res; i_reg_src2 = rs2; i_reg_wen = wen;
        do begin @(negedge i_clk); n++; end while (!o_ready && n < 50);
        if (!o_ready) check("issue_wait", {31'h0, o_ready}, 32'h1);
        @(posedge i_clk);
        #1;
        // Scramble inputs so late changes would corrupt the result if they were sampled.
        i_valid = 1'b0; i_op = 7'h00; i_func = 3'b111;
        i_result = 32'h0BAD_0BAD; i_reg_src2 = 32'hFFFF_FFFF; i_reg_wen = ~wen;
    endtask

    task automatic do_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rs2,
                            input logic [3:0] m, input logic [31:0] wd, input int dly);
        bus_q.push_back('{a & 32'hFFFF_FFFC, 1'b1, m, wd, 32'h0, dly, 0});
        wb_q.push_back('{32'h0, 1'b0, 1'b0, 1'b0});
        issue(OPS, f, a, rs2, 1'b0);
    endtask

    task automatic do_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rd,
                           input logic [31:0] exp, input int dly);
        bus_q.push_back('{a & 32'hFFFF_FFFC, 1'b0, 4'b0000, 32'h0, rd, dly, 0});
        wb_q.push_back('{exp, 1'b1, 1'b0, 1'b1});
        issue(OPL, f, a, 32'h0, 1'b1);
    endtask

    task automatic do_err(input logic [6:0] op, input logic [2:0] f, input logic [31:0] a);
        wb_q.push_back('{32'h0, 1'b0, 1'b1, 1'b1});
        issue(op, f, a, 32'h1234_5678, 1'b1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((wb_q.size() != 0 || bus_q.size() != 0 || !o_ready) && n < 200) begin
            @(negedge i_clk); n++;
        end
        if (n >= 200) check("drain", wb_q.size() + bus_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_op = 7'h0; i_func = 3'h0; i_result = 32'h0;
        i_reg_src2 = 32'h0; i_reg_wen = 1'b0; i_ready = 1'b1; stray_ack = 1'b0;
        #12;
        check("rst_ready", {31'h0, o_ready}, 32'h1);
        check("rst_req", {31'h0, o_mem_req}, 32'h0);
        check("rst_mem_wen", {31'h0, o_mem_wen}, 32'h0);
        check("rst_valid", {31'h0, o_valid}, 32'h0);
        check("rst_err", {31'h0, o_err}, 32'h0);
        check("rst_wb_wen", {31'h0, o_wb_wen}, 32'h0);
        check("rst_wmask", {28'h0, o_mem_wmask}, 32'h0);
        check("rst_addr", o_mem_addr, 32'h0);
        check("rst_wb_data", o_wb_data, 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Stores
        do_store(3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 1);
        do_store(3'b000, 32'h8000_0003, 32'h0000_00A5, 4'b1000, 32'hA500_0000, 0);
        do_store(3'b001, 32'h8000_0002, 32'h1234_ABCD, 4'b1100, 32'hABCD_0000, 2);
        // Loads
        do_load(3'b000, 32'h8000_0001, 32'h1234_F600, 32'hFFFF_FFF6, 0);
        do_load(3'b100, 32'h8000_0001, 32'h1234_F600, 32'h0000_00F6, 1);
        do_load(3'b101, 32'h8000_0002, 32'h8001_0000, 32'h0000_8001, 0);
        do_load(3'b001, 32'h8000_0002, 32'h8001_0000, 32'hFFFF_8001, 0);
        do_load(3'b010, 32'h8000_0008, 32'h1122_3344, 32'h1122_3344, 2);
        // Misaligned / illegal size: no bus cycle, error response
        do_err(OPL, 3'b010, 32'h8000_0002);
        do_err(OPS, 3'b001, 32'h8000_0001);
        do_err(OPL, 3'b011, 32'h8000_0000);
        wait_idle();

        // Pass-through with writeback backpressure
        i_ready = 1'b0;
        wb_q.push_back('{32'h0000_0055, 1'b1, 1'b0, 1'b1});
        issue(OPA, 3'b000, 32'h0000_0055, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            check("hold_valid", {31'h0, o_valid}, 32'h1);
            check("hold_data", o_wb_data, 32'h0000_0055);
            check("hold_ready", {31'h0, o_ready}, 32'h0);
        end
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        @(negedge i_clk);
        check("hs_cycle_ready", {31'h0, o_ready}, 32'h0);
        @(negedge i_clk);
        check("post_hs_ready", {31'h0, o_ready}, 32'h1);
        check("post_hs_valid", {31'h0, o_valid}, 32'h0);

        // Timeout with no ack, then ack exactly on the expiry cycle
        bus_q.push_back('{32'h8000_0010, 1'b0, 4'b0000, 32'h0, 32'h0, 0, 1});
        wb_q.push_back('{32'h0, 1'b0, 1'b1, 1'b1});
        issue(OPL, 3'b010, 32'h8000_0010, 32'h0, 1'b1);
        do_load(3'b010, 32'h8000_0014, 32'hCAFE_F00D, 32'hCAFE_F00D, TO - 1);
        wait_idle();

        // Ack while idle is ignored
        @(posedge i_clk);
        #1;
        stray_ack = 1'b1;
        @(posedge i_clk);
        #1;
        stray_ack = 1'b0;
        @(negedge i_clk);
        check("stray_ack_valid", {31'h0, o_valid}, 32'h0);
        check("stray_ack_ready", {31'h0, o_ready}, 32'h1);

        // Reset asserted mid-MEM drops the request at once
        bus_q.push_back('{32'h8000_0020, 1'b0, 4'b0000, 32'h0, 32'h0, 0, 2});
        issue(OPL, 3'b010, 32'h8000_0020, 32'h0, 1'b1);
        @(negedge i_clk);
        @(negedge i_clk);
        check("pre_rst_req", {31'h0, o_mem_req}, 32'h1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("rst_mid_req", {31'h0, o_mem_req}, 32'h0);
        check("rst_mid_ready", {31'h0, o_ready}, 32'h1);
        check("rst_mid_valid", {31'h0, o_valid}, 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        wb_q.push_back('{32'h0000_0077, 1'b1, 1'b0, 1'b1});
        issue(OPA, 3'b000, 32'h0000_0077, 32'h0, 1'b1);
        wait_idle();
        check("wb_q_empty", wb_q.size(), 0);
        check("bus_q_empty", bus_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
